// File: rtl/servo_pkg.sv
// Shared types, default constants and small helpers for the servo ramp block.
// Widths are 20-bit cycle counts; ramp arithmetic is carried one bit wider.
package servo_pkg;

  localparam int WIDTH_W = 20;
  localparam int ARITH_W = 21;

  localparam int DEF_FRAME_CYCLES = 1000000;
  localparam int DEF_MIN_W        = 50000;
  localparam int DEF_MAX_W        = 100000;
  localparam int DEF_NEUTRAL_W    = 75000;
  localparam int DEF_STEP         = 2500;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } ch_state_e;

  function automatic logic [WIDTH_W-1:0] clamp_width(
    input logic [WIDTH_W-1:0] w,
    input logic [WIDTH_W-1:0] lo,
    input logic [WIDTH_W-1:0] hi
  );
    logic [WIDTH_W-1:0] r;
    r = w;
    if (w < lo) r = lo;
    if (w > hi) r = hi;
    return r;
  endfunction

  function automatic ch_state_e dir_of(
    input logic [WIDTH_W-1:0] cur,
    input logic [WIDTH_W-1:0] tgt
  );
    ch_state_e s;
    s = ST_IDLE;
    if (cur < tgt) s = ST_UP;
    else if (cur > tgt) s = ST_DOWN;
    return s;
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Frame counter: wraps every FRAME_CYCLES cycles, produces the registered frame_tick
// strobe and blocks command acceptance in the last cycle of each frame.
module frame_timer
  import servo_pkg::*;
#(
  parameter int FRAME_CYCLES = DEF_FRAME_CYCLES
) (
  input  logic clk0,
  input  logic rst,
  output logic frame_end,
  output logic frame_tick,
  output logic cmd_ready
);

  localparam logic [WIDTH_W-1:0] LAST_CNT = WIDTH_W'(FRAME_CYCLES - 1);

  logic [WIDTH_W-1:0] cnt_q, cnt_d;
  logic               tick_q;

  assign frame_end = (cnt_q == LAST_CNT);
  assign cnt_d     = frame_end ? '0 : cnt_q + WIDTH_W'(1);

  always_ff @(posedge clk0 or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= frame_end;
    end
  end

  // Widths update on the frame_end edge, so keeping commands out of that cycle
  // means a retarget and a ramp step never collide.
  assign frame_tick = tick_q;
  assign cmd_ready  = ~frame_end;

endmodule

// File: rtl/servo_ramp.sv
// Two-channel servo pulse-width ramp: commands set clamped targets, and each
// channel walks its width toward the target by at most STEP per frame.
module servo_ramp
  import servo_pkg::*;
#(
  parameter int FRAME_CYCLES = DEF_FRAME_CYCLES,
  parameter int MIN_W        = DEF_MIN_W,
  parameter int MAX_W        = DEF_MAX_W,
  parameter int NEUTRAL_W    = DEF_NEUTRAL_W,
  parameter int STEP         = DEF_STEP
) (
  input  logic               clk0,
  input  logic               rst,
  input  logic               cmd_valid,
  input  logic               cmd_ch,
  input  logic [WIDTH_W-1:0] cmd_width,
  output logic               cmd_ready,
  output logic [WIDTH_W-1:0] width1,
  output logic [WIDTH_W-1:0] width2,
  output logic               frame_tick,
  output logic               busy
);

  localparam logic [WIDTH_W-1:0] MIN_L     = WIDTH_W'(MIN_W);
  localparam logic [WIDTH_W-1:0] MAX_L     = WIDTH_W'(MAX_W);
  localparam logic [WIDTH_W-1:0] NEUTRAL_L = WIDTH_W'(NEUTRAL_W);
  localparam logic [ARITH_W-1:0] STEP_A    = ARITH_W'(STEP);

  logic               frame_end;
  logic               cmd_accept;
  logic [WIDTH_W-1:0] cmd_target;
  logic [1:0]         active_d;
  logic [WIDTH_W-1:0] width_arr [2];
  logic               busy_q;

  frame_timer #(
    .FRAME_CYCLES(FRAME_CYCLES)
  ) u_frame_timer (
    .clk0      (clk0),
    .rst       (rst),
    .frame_end (frame_end),
    .frame_tick(frame_tick),
    .cmd_ready (cmd_ready)
  );

  assign cmd_accept = cmd_valid & cmd_ready;
  assign cmd_target = clamp_width(cmd_width, MIN_L, MAX_L);

  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    ch_state_e          state_q, state_d;
    logic [WIDTH_W-1:0] width_q, width_d;
    logic [WIDTH_W-1:0] target_q, target_d;
    logic [ARITH_W-1:0] gap;
    logic [ARITH_W-1:0] next_w;
    logic               sel;

    assign sel = cmd_accept && (cmd_ch == 1'(gi));

    always_comb begin
      state_d  = state_q;
      width_d  = width_q;
      target_d = target_q;
      gap      = '0;
      next_w   = '0;
      if (sel) begin
        target_d = cmd_target;
        state_d  = dir_of(width_q, cmd_target);
      end else if (frame_end) begin
        // Compare the remaining distance with STEP instead of stepping and
        // clamping, so the subtraction can never wrap.
        case (state_q)
          ST_UP: begin
            gap    = {1'b0, target_q} - {1'b0, width_q};
            next_w = {1'b0, width_q} + STEP_A;
            if (gap <= STEP_A) begin
              width_d = target_q;
              state_d = ST_IDLE;
            end else begin
              width_d = next_w[WIDTH_W-1:0];
            end
          end
          ST_DOWN: begin
            gap    = {1'b0, width_q} - {1'b0, target_q};
            next_w = {1'b0, width_q} - STEP_A;
            if (gap <= STEP_A) begin
              width_d = target_q;
              state_d = ST_IDLE;
            end else begin
              width_d = next_w[WIDTH_W-1:0];
            end
          end
          default: ;
        endcase
      end
    end

    always_ff @(posedge clk0 or posedge rst) begin
      if (rst) begin
        state_q  <= ST_IDLE;
        width_q  <= NEUTRAL_L;
        target_q <= NEUTRAL_L;
      end else begin
        state_q  <= state_d;
        width_q  <= width_d;
        target_q <= target_d;
      end
    end

    assign active_d[gi]  = (state_d != ST_IDLE);
    assign width_arr[gi] = width_q;
  end

  always_ff @(posedge clk0 or posedge rst) begin
    if (rst) busy_q <= 1'b0;
    else     busy_q <= |active_d;
  end

  assign busy   = busy_q;
  assign width1 = width_arr[0];
  assign width2 = width_arr[1];

endmodule

// File: tb/tb_servo_ramp.sv
// Directed bench for servo_ramp with a 100-cycle frame: a command table with
// hand-computed clamp/tick/final values plus sequences for reset, handshake and retarget.
module tb_servo_ramp;

  logic        clk0 = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ch = 1'b0;
  logic [19:0] cmd_width = '0;
  logic        cmd_ready;
  logic [19:0] width1, width2;
  logic        frame_tick;
  logic        busy;

  int checks = 0;
  int errors = 0;

  servo_ramp #(
    .FRAME_CYCLES(100),
    .MIN_W       (50000),
    .MAX_W       (100000),
    .NEUTRAL_W   (75000),
    .STEP        (2500)
  ) dut (
    .clk0      (clk0),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ch    (cmd_ch),
    .cmd_width (cmd_width),
    .cmd_ready (cmd_ready),
    .width1    (width1),
    .width2    (width2),
    .frame_tick(frame_tick),
    .busy      (busy)
  );

  always #5 clk0 = ~clk0;

  typedef struct {
    bit ch;
    int cmd_w;
    bit exp_busy;
    int exp_ticks;
    int exp_final;
  } vec_t;

  vec_t vecs [7];
  int   cur_w [2];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int w_of(input bit ch);
    return ch ? int'(width2) : int'(width1);
  endfunction

  function automatic int model_step(input int w, input int t);
    if (w < t) return (w + 2500 < t) ? w + 2500 : t;
    if (w > t) return (w - 2500 > t) ? w - 2500 : t;
    return w;
  endfunction

  // Returns at the negedge where frame_tick is high; must be entered at a negedge.
  task automatic wait_tick();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk0);
      if (frame_tick) begin
        ok = 1'b1;
        break;
      end
    end
    check("tick_timeout", int'(ok), 1);
  endtask

  // Must be entered at a negedge; returns at the negedge after acceptance.
  task automatic send_cmd(input bit ch, input int w);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk0);
    end
    check("ready_timeout", int'(ok), 1);
    cmd_valid = 1'b1;
    cmd_ch    = ch;
    cmd_width = 20'(w);
    @(negedge clk0);
    cmd_valid = 1'b0;
    $display("cmd ch%0d width %0d accepted at %0t", ch, w, $time);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit ok;

    vecs[0] = '{ch: 1'b0, cmd_w: 80000,   exp_busy: 1'b1, exp_ticks: 2,  exp_final: 80000};
    vecs[1] = '{ch: 1'b1, cmd_w: 20000,   exp_busy: 1'b1, exp_ticks: 10, exp_final: 50000};
    vecs[2] = '{ch: 1'b0, cmd_w: 80000,   exp_busy: 1'b0, exp_ticks: 0,  exp_final: 80000};
    vecs[3] = '{ch: 1'b1, cmd_w: 200000,  exp_busy: 1'b1, exp_ticks: 20, exp_final: 100000};
    vecs[4] = '{ch: 1'b0, cmd_w: 81234,   exp_busy: 1'b1, exp_ticks: 1,  exp_final: 81234};
    vecs[5] = '{ch: 1'b0, cmd_w: 50000,   exp_busy: 1'b1, exp_ticks: 13, exp_final: 50000};
    vecs[6] = '{ch: 1'b1, cmd_w: 1048575, exp_busy: 1'b0, exp_ticks: 0,  exp_final: 100000};
    cur_w[0] = 75000;
    cur_w[1] = 75000;

    // Reset state and frame_tick period
    repeat (3) @(negedge clk0);
    rst = 1'b0;
    check("rst_width1", int'(width1), 75000);
    check("rst_width2", int'(width2), 75000);
    check("rst_busy", int'(busy), 0);
    check("rst_ready", int'(cmd_ready), 1);
    check("rst_tick", int'(frame_tick), 0);
    n = 0;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk0);
      n++;
      if (frame_tick) begin
        ok = 1'b1;
        break;
      end
    end
    check("first_tick_found", int'(ok), 1);
    check("first_tick_cycle", n, 100);
    @(negedge clk0);
    check("tick_one_cycle", int'(frame_tick), 0);
    n = 1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk0);
      n++;
      if (frame_tick) break;
    end
    check("tick_period", n, 100);
    check("idle_width1", int'(width1), 75000);
    $display("reset/tick period done at %0t", $time);

    // Command table
    for (int v = 0; v < 7; v++) begin
      int nt;
      bit ch;
      ch = vecs[v].ch;
      send_cmd(ch, vecs[v].cmd_w);
      check("accept_busy", int'(busy), int'(vecs[v].exp_busy));
      check("accept_hold", w_of(ch), cur_w[ch]);
      nt = (vecs[v].exp_ticks == 0) ? 1 : vecs[v].exp_ticks;
      for (int k = 0; k < nt; k++) begin
        wait_tick();
        cur_w[ch] = model_step(cur_w[ch], vecs[v].exp_final);
        check("ramp_width", w_of(ch), cur_w[ch]);
        check("other_width", w_of(!ch), cur_w[!ch]);
        check("ramp_busy", int'(busy), (k + 1 < vecs[v].exp_ticks) ? 1 : 0);
      end
      check("final_width", w_of(ch), vecs[v].exp_final);
      $display("vector %0d ch%0d cmd %0d -> width %0d", v, ch, vecs[v].cmd_w, w_of(ch));
    end

    // Handshake boundary: valid held across the last cycle of a frame
    n = 0;
    while (cmd_ready && n < 300) begin
      @(negedge clk0);
      n++;
    end
    check("ready_low", int'(cmd_ready), 0);
    cmd_valid = 1'b1;
    cmd_ch    = 1'b0;
    cmd_width = 20'd77500;
    @(negedge clk0);
    check("boundary_tick", int'(frame_tick), 1);
    check("boundary_ready", int'(cmd_ready), 1);
    check("boundary_not_accepted", int'(busy), 0);
    check("boundary_width1", int'(width1), 50000);
    @(negedge clk0);
    cmd_valid = 1'b0;
    check("boundary_accepted", int'(busy), 1);
    for (int k = 0; k < 11; k++) wait_tick();
    check("boundary_final", int'(width1), 77500);
    check("boundary_idle", int'(busy), 0);
    $display("handshake boundary done at %0t", $time);

    // Retarget mid-ramp: up toward 100000, then down to 76000 before any step
    send_cmd(1'b0, 100000);
    check("retgt_busy_up", int'(busy), 1);
    send_cmd(1'b0, 76000);
    check("retgt_hold", int'(width1), 77500);
    check("retgt_busy_down", int'(busy), 1);
    wait_tick();
    check("retgt_width", int'(width1), 76000);
    check("retgt_idle", int'(busy), 0);
    wait_tick();
    check("retgt_stays", int'(width1), 76000);
    $display("retarget done at %0t", $time);

    // Asynchronous reset in the middle of a ramp
    send_cmd(1'b0, 80000);
    wait_tick();
    wait_tick();
    check("pre_width", int'(width1), 80000);
    send_cmd(1'b0, 100000);
    wait_tick();
    wait_tick();
    check("mid_width", int'(width1), 85000);
    check("mid_busy", int'(busy), 1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_width1", int'(width1), 75000);
    check("arst_width2", int'(width2), 75000);
    check("arst_busy", int'(busy), 0);
    check("arst_tick", int'(frame_tick), 0);
    check("arst_ready", int'(cmd_ready), 1);
    @(negedge clk0);
    rst = 1'b0;
    wait_tick();
    check("post_width1", int'(width1), 75000);
    check("post_busy", int'(busy), 0);
    wait_tick();
    check("post_width1_b", int'(width1), 75000);
    check("post_width2", int'(width2), 75000);
    $display("reset mid-ramp done at %0t", $time);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/servo_ramp.md
SERVO_RAMP -- requirements
Module: servo_ramp

Interface
REQ-001 SHALL have parameter FRAME_CYCLES, default 1000000, meaning clock cycles per servo frame (20 ms at 50 MHz).
REQ-002 SHALL have parameter MIN_W, default 50000, meaning minimum pulse width in cycles.
REQ-003 SHALL have parameter MAX_W, default 100000, meaning maximum pulse width in cycles.
REQ-004 SHALL have parameter NEUTRAL_W, default 75000, meaning pulse width after reset.
REQ-005 SHALL have parameter STEP, default 2500, meaning maximum width change per channel per frame.
REQ-006 SHALL have port clk0, input, 1 bit: the single clock; all logic is on posedge clk0.
REQ-007 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-008 SHALL have port cmd_valid, input, 1 bit: a command is present.
REQ-009 SHALL have port cmd_ch, input, 1 bit: target channel; 0 is channel 1 (clockwise), 1 is channel 2 (counter-clockwise).
REQ-010 SHALL have port cmd_width, input, 20 bits: requested pulse width in cycles.
REQ-011 SHALL have port cmd_ready, output, 1 bit: the block accepts a command this cycle.
REQ-012 SHALL have port width1, output, 20 bits: current pulse width for channel 1, to the downstream PWM generator.
REQ-013 SHALL have port width2, output, 20 bits: current pulse width for channel 2, to the downstream PWM generator.
REQ-014 SHALL have port frame_tick, output, 1 bit: one-cycle strobe at frame boundary.
REQ-015 SHALL have port busy, output, 1 bit: at least one channel is ramping.

Function
REQ-016 SHALL count frames with a 20-bit counter running 0..FRAME_CYCLES-1 and wrapping to 0.
REQ-017 SHALL assert frame_tick for exactly one cycle, in the cycle after the counter equals FRAME_CYCLES-1 (registered output).
REQ-018 SHALL drive cmd_ready low in the cycle the counter equals FRAME_CYCLES-1 and high in all other cycles.
REQ-019 SHALL accept a command on the rising edge when cmd_valid and cmd_ready are both high; handshake latency is 0 cycles.
REQ-020 SHALL clamp an accepted cmd_width to [MIN_W, MAX_W] and store it as the target of the channel selected by cmd_ch.
REQ-021 SHALL run one FSM per channel with states IDLE (width==target), UP (width<target) and DOWN (width>target).
REQ-022 SHALL, on command accept, enter UP, DOWN or IDLE in the next cycle by comparing the current width with the new target.
REQ-023 SHALL, on each frame_tick, in UP set width=min(width+STEP, target) and in DOWN set width=max(width-STEP, target).
REQ-024 SHALL return a channel to IDLE on the frame_tick at which width reaches target; a channel SHALL never overshoot its target.
REQ-025 SHALL let a command that arrives mid-ramp retarget the channel, with direction re-evaluated; the width SHALL hold until the next frame_tick.
REQ-026 SHALL change width1 and width2 only in the cycle of frame_tick, so the downstream PWM never sees a mid-frame change.
REQ-027 SHALL treat a command whose target equals the current width as a no-op and keep the channel in IDLE.
REQ-028 SHALL drive busy high iff either channel FSM is not IDLE; busy is registered.
REQ-029 SHALL perform all width arithmetic in 21 bits so that width+STEP cannot wrap.

Reset
REQ-030 SHALL, while rst is high, force: counter=0, frame_tick=0, width1=width2=target1=target2=NEUTRAL_W, both FSMs IDLE, busy=0.
REQ-031 SHALL drive cmd_ready=1 after reset deassertion, which follows from counter=0.
REQ-032 SHALL abort any ramp when rst is asserted mid-operation and restart in the reset state; no command SHALL be retained.

Structure
REQ-033 SHALL place the state typedef (IDLE/UP/DOWN) and the default constants in the shared package servo_pkg.
REQ-034 SHALL use one sub-module, frame_timer (counter plus frame_tick and cmd_ready generation), instantiated once.
REQ-035 SHALL keep both channel FSMs in servo_ramp, as two instances of identical logic.

Verification (FRAME_CYCLES=100, MIN_W=50000, MAX_W=100000, NEUTRAL_W=75000, STEP=2500)
REQ-036 SHALL check reset: rst pulse -> width1=width2=75000, busy=0, cmd_ready=1, frame_tick high every 100 cycles and never wider than 1 cycle.
REQ-037 SHALL check ramp up: cmd ch0 width 80000 -> busy=1; width1 = 77500 then 80000 on two successive frame_ticks; IDLE and busy=0 after the second tick; width2 stays 75000.
REQ-038 SHALL check clamp: cmd ch1 width 20000 -> target2=50000; width2 reaches 50000 after 10 frame_ticks, decreasing 2500 per tick.
REQ-039 SHALL check the handshake boundary: cmd_valid held across the counter=99 cycle -> not accepted in that cycle, accepted in the following cycle.
REQ-040 SHALL check retarget: ch0 ramping up toward 100000 from 77500 gets cmd 76000 -> next tick width1=76000 (DOWN, no overshoot), then IDLE.
REQ-041 SHALL check reset mid-ramp: rst asserted while width1=85000 -> width1=75000 immediately (async), busy=0, no pending ramp after release.
